// File: rtl/jimbo_pin_bridge_if.sv
// Core-side request/acknowledge bus of the Jimbo pin bridge.
//   master : the CPU core (drives request, write flag, address, write data)
//   slave  : jimbo_pin_bridge (returns read data, ack pulse, error flag)
// Parameters: ADDR_W core address width, DATA_W core data width.
interface jimbo_pin_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ack;
  logic              core_err;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack, core_err
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack, core_err
  );
endinterface

// File: rtl/jimbo_pin_bridge.sv
// Jimbo CPU core to TinyTapeout pin ring bridge.
// A core request is turned into a multiplexed pin transaction: the address is
// sent in PIN_W-bit chunks (most significant first, top chunk zero-padded),
// then a data phase of WAIT_MIN+1 cycles minimum, stretchable by pin_wait,
// then a one-cycle core_ack.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   core          jimbo_pin_bridge_if.slave (req/we/addr/wdata in, rdata/ack/err out)
//   pin_addr      current address chunk        pin_ale      address-latch strobe
//   pin_we        write strobe (write data)    pin_data_out write data
//   pin_data_oe   data pin output enable       pin_data_in  read data from pins
//   pin_wait      external wait, stretches the data phase
// Optional feature: define JIMBO_BRIDGE_TIMEOUT_EN to bound the wait stretch
// to TIMEOUT cycles; a timed-out transaction acks with core_err=1 and reads
// return all-ones. Without it core_err is tied low.
// Every output is a flop driven from the registered state, so pins and core
// outputs show the state one cycle after it is entered.
module jimbo_pin_bridge #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int PIN_W    = 8,
  parameter int WAIT_MIN = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  jimbo_pin_bridge_if.slave core,
  output logic [PIN_W-1:0]  pin_addr,
  output logic              pin_ale,
  output logic              pin_we,
  output logic [DATA_W-1:0] pin_data_out,
  output logic              pin_data_oe,
  input  logic [DATA_W-1:0] pin_data_in,
  input  logic              pin_wait
);

  localparam int N_CHUNK = (ADDR_W + PIN_W - 1) / PIN_W;
  localparam int PAD_W   = N_CHUNK * PIN_W;
  localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int WAIT_W  = 4;
  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(N_CHUNK - 1);

  // Reject parameter values the wait counter and timeout cannot represent.
  if (WAIT_MIN < 0 || WAIT_MIN > 15 || TIMEOUT < 1) begin : g_param_check
    $error("jimbo_pin_bridge: WAIT_MIN must be 0..15 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                accept_s, data_done_s, data_phase_wr_s;
  logic                we_r;
  logic [PAD_W-1:0]    addr_sh_r;    // padded address, shifted left per chunk
  logic [DATA_W-1:0]   wdata_r;
  logic [CHUNK_W-1:0]  chunk_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [DATA_W-1:0]   core_rdata_r, pin_data_out_r;
  logic [PIN_W-1:0]    pin_addr_r;
  logic                core_ack_r, pin_ale_r, pin_we_r, pin_data_oe_r;

`ifdef JIMBO_BRIDGE_TIMEOUT_EN
  localparam int STRETCH_W = $clog2(TIMEOUT + 1);
  logic [STRETCH_W-1:0] stretch_r;
  logic                 timeout_hit_s, stretch_inc_s, timed_out_r, core_err_r;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and per-cycle control decisions.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    data_done_s = 1'b0;
`ifdef JIMBO_BRIDGE_TIMEOUT_EN
    timeout_hit_s = 1'b0;
    stretch_inc_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (core.core_req) begin
          state_nxt_s = ST_ADDR;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (chunk_r == CHUNK_LAST) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        // pin_wait only matters once the minimum wait cycles are spent.
        if (wait_cnt_r != 4'd0) begin
          state_nxt_s = ST_DATA;
`ifdef JIMBO_BRIDGE_TIMEOUT_EN
        end else if (stretch_r == STRETCH_W'(TIMEOUT)) begin
          state_nxt_s   = ST_ACK;
          timeout_hit_s = 1'b1;
`endif
        end else if (!pin_wait) begin
          state_nxt_s = ST_ACK;
          data_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_DATA;
`ifdef JIMBO_BRIDGE_TIMEOUT_EN
          stretch_inc_s = 1'b1;
`endif
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign data_phase_wr_s = (state_r == ST_DATA) && we_r;

  // Request latching, address chunking, wait counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r         <= 1'b0;
      addr_sh_r    <= '0;
      wdata_r      <= '0;
      chunk_r      <= '0;
      wait_cnt_r   <= '0;
      core_rdata_r <= '0;
    end else begin
      if (accept_s) begin
        we_r      <= core.core_we;
        addr_sh_r <= PAD_W'(core.core_addr);
        wdata_r   <= core.core_wdata;
        chunk_r   <= '0;
      end else if (state_r == ST_ADDR) begin
        addr_sh_r <= addr_sh_r << PIN_W;
        chunk_r   <= chunk_r + CHUNK_W'(1);
      end
      if (state_r == ST_ADDR && state_nxt_s == ST_DATA) begin
        wait_cnt_r <= WAIT_W'(WAIT_MIN);
      end else if (state_r == ST_DATA && wait_cnt_r != 4'd0) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end
      if (data_done_s && !we_r) begin
        core_rdata_r <= pin_data_in;
`ifdef JIMBO_BRIDGE_TIMEOUT_EN
      end else if (timeout_hit_s && !we_r) begin
        core_rdata_r <= '1;
`endif
      end
    end
  end

  // Registered pin strobes and core acknowledge, derived from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_addr_r     <= '0;
      pin_ale_r      <= 1'b0;
      pin_we_r       <= 1'b0;
      pin_data_oe_r  <= 1'b0;
      pin_data_out_r <= '0;
      core_ack_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: pin_addr_r <= addr_sh_r[PAD_W-1 -: PIN_W];
        ST_DATA: pin_addr_r <= pin_addr_r;   // hold the last chunk
        default: pin_addr_r <= '0;
      endcase
      pin_ale_r      <= (state_r == ST_ADDR);
      pin_we_r       <= data_phase_wr_s;
      pin_data_oe_r  <= data_phase_wr_s;
      pin_data_out_r <= data_phase_wr_s ? wdata_r : '0;
      core_ack_r     <= (state_r == ST_ACK);
    end
  end

`ifdef JIMBO_BRIDGE_TIMEOUT_EN
  // Stretch counter and timeout flag; the counter restarts on every DATA entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stretch_r   <= '0;
      timed_out_r <= 1'b0;
      core_err_r  <= 1'b0;
    end else begin
      if (state_r == ST_ADDR && state_nxt_s == ST_DATA) begin
        stretch_r <= '0;
      end else if (stretch_inc_s) begin
        stretch_r <= stretch_r + STRETCH_W'(1);
      end
      if (accept_s) begin
        timed_out_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timed_out_r <= 1'b1;
      end
      core_err_r <= (state_r == ST_ACK) && timed_out_r;
    end
  end
  assign core.core_err = core_err_r;
`else
  assign core.core_err = 1'b0;
`endif

  assign core.core_rdata = core_rdata_r;
  assign core.core_ack   = core_ack_r;
  assign pin_addr        = pin_addr_r;
  assign pin_ale         = pin_ale_r;
  assign pin_we          = pin_we_r;
  assign pin_data_out    = pin_data_out_r;
  assign pin_data_oe     = pin_data_oe_r;

endmodule

// File: tb/tb_jimbo_pin_bridge.sv
// Self-checking bench for jimbo_pin_bridge. Two instances: A with the default
// geometry (12-bit address, 8-bit chunks, 4-bit data, WAIT_MIN=1) and B with a
// single 16-bit chunk, 8-bit data and WAIT_MIN=0. Expected pin/ack waveforms
// are computed per cycle from the transaction description (chunk arithmetic,
// phase lengths), not from the design's state machine.
module tb_jimbo_pin_bridge;
  localparam int TO_CYC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jimbo_pin_bridge_if #(.ADDR_W(12), .DATA_W(4)) ca ();
  jimbo_pin_bridge_if #(.ADDR_W(16), .DATA_W(8)) cb ();

  logic [7:0]  pa_addr;
  logic        pa_ale, pa_we, pa_oe, pa_wait;
  logic [3:0]  pa_dout, pa_din;
  logic [15:0] pb_addr;
  logic        pb_ale, pb_we, pb_oe, pb_wait;
  logic [7:0]  pb_dout, pb_din;

  jimbo_pin_bridge #(.ADDR_W(12), .DATA_W(4), .PIN_W(8), .WAIT_MIN(1), .TIMEOUT(TO_CYC)) dut_a (
    .clk(clk), .rst_n(rst_n), .core(ca),
    .pin_addr(pa_addr), .pin_ale(pa_ale), .pin_we(pa_we), .pin_data_out(pa_dout),
    .pin_data_oe(pa_oe), .pin_data_in(pa_din), .pin_wait(pa_wait)
  );

  jimbo_pin_bridge #(.ADDR_W(16), .DATA_W(8), .PIN_W(16), .WAIT_MIN(0), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .core(cb),
    .pin_addr(pb_addr), .pin_ale(pb_ale), .pin_we(pb_we), .pin_data_out(pb_dout),
    .pin_data_oe(pb_oe), .pin_data_in(pb_din), .pin_wait(pb_wait)
  );

  int total = 0;
  int bad   = 0;
  int mdl_rdata [2];   // last completed read value per instance

  // Packed view {ale, we, oe, ack, err, addr[15:0], dout[7:0]} of one instance.
  function automatic logic [28:0] obs_pack(input bit b);
    if (b) return {pb_ale, pb_we, pb_oe, cb.core_ack, cb.core_err, pb_addr, pb_dout};
    else   return {pa_ale, pa_we, pa_oe, ca.core_ack, ca.core_err, 8'h00, pa_addr, 4'h0, pa_dout};
  endfunction

  function automatic logic [7:0] obs_rdata(input bit b);
    if (b) return cb.core_rdata;
    else   return {4'h0, ca.core_rdata};
  endfunction

  task automatic drive_core(input bit b, input bit req, input bit we, input int addr, input int wd);
    if (b) begin
      cb.core_req = req; cb.core_we = we; cb.core_addr = 16'(addr); cb.core_wdata = 8'(wd);
    end else begin
      ca.core_req = req; ca.core_we = we; ca.core_addr = 12'(addr); ca.core_wdata = 4'(wd);
    end
  endtask

  task automatic drive_pins(input bit b, input bit w, input int din);
    if (b) begin pb_wait = w; pb_din = 8'(din); end
    else   begin pa_wait = w; pa_din = 4'(din); end
  endtask

  // One transaction; core inputs are scrambled after acceptance. to=1 holds
  // pin_wait high until the timeout fires. Ends right after the ack cycle.
  task automatic txn(input bit b, input bit we, input int addr, input int wd, input int rd,
                     input int stretch, input bit to);
    int n, wm, pw, aw, dw, d, l, cap, extra, val, ex_pa, ex_rd;
    bit ex_ale, ex_dp, ex_we, ex_ack, ex_err, w;
    logic [28:0] ex_v, ob_v;
    n  = b ? 1 : 2;   wm = b ? 0 : 1;
    pw = b ? 16 : 8;  aw = b ? 16 : 12; dw = b ? 8 : 4;
    val = addr & ((1 << aw) - 1);
    wd  = wd & ((1 << dw) - 1);
    rd  = rd & ((1 << dw) - 1);
    extra = to ? TO_CYC : stretch;
    d   = wm + 1 + extra;
    l   = n + d + 1;
    cap = n + wm + 1 + extra;           // edge that leaves the data phase
    ex_rd = we ? mdl_rdata[b] : (to ? (1 << dw) - 1 : rd);
    drive_core(b, 1'b1, we, val, wd);
    @(negedge clk);
    for (int c = 0; c <= l; c++) begin
      if (c > 0) begin
        drive_core(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
        if (c < n + wm + 1 || c > cap) w = 1'($urandom_range(0, 1));
        else if (c < cap)              w = 1'b1;
        else                           w = to;
        drive_pins(b, w, (c == cap && !to) ? rd : int'($urandom_range(0, 255)));
        @(negedge clk);
      end
      ex_ale = (c >= 1 && c <= n);
      ex_dp  = (c >= n + 1 && c <= n + d);
      ex_we  = we && ex_dp;
      ex_ack = (c == l);
      ex_err = ex_ack && to;
      if (ex_ale)     ex_pa = (val >> (pw * (n - c))) & ((1 << pw) - 1);
      else if (ex_dp) ex_pa = val & ((1 << pw) - 1);
      else            ex_pa = 0;
      ex_v = {ex_ale, ex_we, ex_we, ex_ack, ex_err, 16'(ex_pa), ex_we ? 8'(wd) : 8'h00};
      ob_v = obs_pack(b);
      total++;
      if (ob_v !== ex_v) begin
        bad++;
        $display("FAIL pins_%0d cycle %0d: got %h want %h", b, c, ob_v, ex_v);
      end
      if (c == 0 || c == l) begin
        total++;
        if (obs_rdata(b) !== 8'((c == 0) ? mdl_rdata[b] : ex_rd)) begin
          bad++;
          $display("FAIL rdata_%0d cycle %0d: got %h want %h", b, c, obs_rdata(b),
                   8'((c == 0) ? mdl_rdata[b] : ex_rd));
        end
      end
    end
    mdl_rdata[b] = ex_rd;
  endtask

  task automatic idle(input bit b, input int ncyc);
    drive_core(b, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < ncyc; i++) begin
      drive_pins(b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      @(negedge clk);
      total++;
      if (obs_pack(b) !== 29'd0) begin
        bad++;
        $display("FAIL idle_%0d: got %h want 0", b, obs_pack(b));
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_core(1'b0, 1'b0, 1'b0, 0, 0); drive_core(1'b1, 1'b0, 1'b0, 0, 0);
    drive_pins(1'b0, 1'b0, 0);          drive_pins(1'b1, 1'b0, 0);
    mdl_rdata[0] = 0; mdl_rdata[1] = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({obs_pack(0), obs_rdata(0), obs_pack(1), obs_rdata(1)} !== 74'd0) begin
      bad++;
      $display("FAIL reset_state: got %h/%h want 0", obs_pack(0), obs_pack(1));
    end
    rst_n = 1'b1;
    idle(1'b0, 2);
    idle(1'b1, 1);
  endtask

  task automatic test_default_read;
    txn(1'b0, 1'b0, 12'hABC, 0, 4'h5, 0, 1'b0);
    idle(1'b0, 1);
  endtask

  task automatic test_write;
    txn(1'b0, 1'b1, 12'h123, 4'h3, 0, 0, 1'b0);
    idle(1'b0, 2);
  endtask

  task automatic test_wait_stretch;
    txn(1'b0, 1'b0, 12'h7E1, 0, 4'hA, 7, 1'b0);
    idle(1'b0, 1);
  endtask

  task automatic test_random_a;
    int gap;
    for (int i = 0; i < 12; i++) begin
      txn(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 5)), 1'b0);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(1'b0, gap);
    end
    idle(1'b0, 1);
  endtask

`ifdef JIMBO_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    txn(1'b0, 1'b0, 12'h456, 0, 4'h2, 0, 1'b1);
    idle(1'b0, 1);
    txn(1'b0, 1'b1, 12'h654, 4'h6, 0, 0, 1'b1);
    idle(1'b0, 1);
  endtask
`else
  task automatic test_no_timeout;
    int rd;
    rd = int'($urandom_range(0, 15));
    drive_core(1'b0, 1'b1, 1'b0, 12'h9D2, 0);
    @(negedge clk);
    for (int c = 1; c <= 100; c++) begin
      drive_core(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)));
      drive_pins(1'b0, (c >= 4) ? 1'b1 : 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      @(negedge clk);
      total++;
      if (ca.core_ack !== 1'b0) begin
        bad++;
        $display("FAIL no_timeout_wait cycle %0d: got ack %b want 0", c, ca.core_ack);
      end
    end
    drive_core(1'b0, 1'b0, 1'b0, 0, 0);
    drive_pins(1'b0, 1'b0, rd);
    @(negedge clk);
    drive_pins(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    @(negedge clk);
    total++;
    if ({ca.core_ack, ca.core_err, ca.core_rdata} !== {1'b1, 1'b0, 4'(rd)}) begin
      bad++;
      $display("FAIL no_timeout_release: got %b%b %h want 10 %h",
               ca.core_ack, ca.core_err, ca.core_rdata, 4'(rd));
    end
    mdl_rdata[0] = rd;
    idle(1'b0, 2);
  endtask
`endif

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      txn(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 255)), int'($urandom_range(1, 255)),
          (i < 4) ? 0 : int'($urandom_range(0, 3)), 1'b0);
    end
    txn(1'b1, 1'b0, 16'hBEEF, 0, 8'hC3, 0, 1'b0);
    idle(1'b1, 2);
  endtask

  task automatic test_reset_abort;
    drive_core(1'b0, 1'b1, 1'b1, 12'h5A5, 4'h9);
    @(negedge clk);
    drive_core(1'b0, 1'b0, 1'b0, 0, 0);
    drive_pins(1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (pa_we !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_we: got %b want 1", pa_we);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({obs_pack(0), obs_rdata(0), obs_pack(1), obs_rdata(1)} !== 74'd0) begin
      bad++;
      $display("FAIL abort_async: got %h %h / %h %h want 0", obs_pack(0), obs_rdata(0),
               obs_pack(1), obs_rdata(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_rdata[0] = 0; mdl_rdata[1] = 0;
    idle(1'b0, 8);
    idle(1'b1, 2);
    txn(1'b0, 1'b0, 12'h0F0, 0, 4'hE, 1, 1'b0);
    idle(1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_default_read();
    test_write();
    test_wait_stretch();
    test_random_a();
`ifdef JIMBO_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
